// File: rtl/dog_layer_stream.sv
// dog_layer_stream: streaming difference-of-Gaussians across adjacent blur layers with border masking and per-frame candidate counting.
module dog_layer_stream #(
  parameter int PIX_W  = 8,
  parameter int LAYERS = 4,
  parameter int DOG_W  = 9,
  parameter int COLS   = 640,
  parameter int ROWS   = 480,
  parameter int BORDER = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [LAYERS*PIX_W-1:0]       in_data,
  input  logic                          mode,
  input  logic [DOG_W-2:0]              thresh,
  output logic                          out_valid,
  output logic [(LAYERS-1)*DOG_W-1:0]   out_data,
  output logic [LAYERS-2:0]             out_cand,
  output logic [$clog2(COLS)-1:0]       out_col,
  output logic [$clog2(ROWS)-1:0]       out_row,
  output logic                          frame_done,
  output logic [19:0]                   cand_count
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int ND = LAYERS - 1;
  localparam int WW = (DOG_W > PIX_W + 1 ? DOG_W : PIX_W + 1) + 1;
  localparam logic signed [WW-1:0] DMAX = WW'((1 << (DOG_W - 1)) - 1);
  localparam logic signed [WW-1:0] DMIN = ~DMAX;
  logic [CW-1:0] col, s1_col, s2_col;
  logic [RW-1:0] row, s1_row, s2_row;
  logic mode_q, first, last_col, last_row, mask_in;
  logic [DOG_W-2:0] thresh_q, s1_thresh;
  logic s1_v, s1_mask, s1_last, s1_mode;
  logic [LAYERS*PIX_W-1:0] s1_data;
  logic s2_v, s2_last;
  logic [ND*DOG_W-1:0] s2_d, d_n;
  logic [ND-1:0] s2_c, c_n;
  logic [19:0] acc, acc_n;
  // Candidate test uses the true magnitude, before saturation to DOG_W.
  function automatic logic [DOG_W:0] dog(input logic [PIX_W-1:0] lo, input logic [PIX_W-1:0] hi,
                                         input logic m, input logic [DOG_W-2:0] t);
    logic signed [WW-1:0] dw, aw, sw, ow;
    dw = signed'(WW'(hi)) - signed'(WW'(lo));
    aw = dw < 0 ? -dw : dw;
    sw = dw > DMAX ? DMAX : dw < DMIN ? DMIN : dw;
    ow = m && sw < 0 ? (sw == DMIN ? DMAX : -sw) : sw;
    return {aw > signed'(WW'(t)), ow[DOG_W-1:0]};
  endfunction
  assign first    = col == '0 && row == '0;
  assign last_col = col == CW'(COLS - 1);
  assign last_row = row == RW'(ROWS - 1);
  assign mask_in  = col < CW'(BORDER) || col >= CW'(COLS - BORDER) ||
                    row < RW'(BORDER) || row >= RW'(ROWS - BORDER);
  assign acc_n    = &acc ? acc : acc + 20'(|s2_c);
  always_comb begin
    d_n = '0;
    c_n = '0;
    for (int j = 0; j < ND; j++)
      {c_n[j], d_n[j*DOG_W +: DOG_W]} = dog(s1_data[j*PIX_W +: PIX_W], s1_data[(j+1)*PIX_W +: PIX_W],
                                            s1_mode, s1_thresh);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= 1'b0;
      thresh_q  <= '0;
      s1_v      <= 1'b0;
      s1_data   <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_mask   <= 1'b0;
      s1_last   <= 1'b0;
      s1_mode   <= 1'b0;
      s1_thresh <= '0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) row <= last_row ? '0 : row + 1'b1;
        if (first) begin
          mode_q   <= mode;
          thresh_q <= thresh;
        end
        s1_data   <= in_data;
        s1_col    <= col;
        s1_row    <= row;
        s1_mask   <= mask_in;
        s1_last   <= last_col && last_row;
        s1_mode   <= first ? mode : mode_q;
        s1_thresh <= first ? thresh : thresh_q;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v       <= 1'b0;
      s2_d       <= '0;
      s2_c       <= '0;
      s2_col     <= '0;
      s2_row     <= '0;
      s2_last    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_cand   <= '0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
      cand_count <= '0;
      acc        <= '0;
    end else begin
      s2_v       <= s1_v;
      out_valid  <= s2_v;
      frame_done <= s2_v && s2_last;
      if (s1_v) begin
        s2_d    <= s1_mask ? '0 : d_n;
        s2_c    <= s1_mask ? '0 : c_n;
        s2_col  <= s1_col;
        s2_row  <= s1_row;
        s2_last <= s1_last;
      end
      if (s2_v) begin
        out_data <= s2_d;
        out_cand <= s2_c;
        out_col  <= s2_col;
        out_row  <= s2_row;
        acc      <= s2_last ? '0 : acc_n;
        if (s2_last) cand_count <= acc_n;
      end
    end
  end
endmodule

// File: tb/tb_dog_layer_stream.sv
// tb_dog_layer_stream: table vectors plus randomized frames against a per-pixel arithmetic model, on DOG_W=9 and DOG_W=6 builds.
module tb_dog_layer_stream;
  localparam int COLS = 8, ROWS = 4, NPIX = COLS * ROWS;
  typedef struct packed {
    logic v;
    logic [17:0] d9;
    logic [1:0] c9;
    logic [11:0] d6;
    logic [1:0] c6;
    logic [2:0] col;
    logic [1:0] row;
    logic fd;
    logic [19:0] cc9;
    logic [19:0] cc6;
  } exp_t;
  typedef struct {
    logic [23:0] din;
    int e0, e1, f0, f1;
    logic [1:0] ec;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, mode = 0;
  logic [23:0] in_data = '0;
  logic [7:0] thresh = '0;
  logic out_valid, frame_done, out_valid6, frame_done6;
  logic [17:0] out_data;
  logic [11:0] out_data6;
  logic [1:0] out_cand, out_cand6, out_row, out_row6;
  logic [2:0] out_col, out_col6;
  logic [19:0] cand_count, cand_count6;
  int nvec = 0, nerr = 0, n_ov = 0, n_fd = 0;
  int p, acc9, acc6, cc9, cc6, tl;
  bit ml;
  exp_t q[$];
  vec_t tv[6];

  dog_layer_stream #(.PIX_W(8), .LAYERS(3), .DOG_W(9), .COLS(COLS), .ROWS(ROWS), .BORDER(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode), .thresh(thresh),
    .out_valid(out_valid), .out_data(out_data), .out_cand(out_cand), .out_col(out_col),
    .out_row(out_row), .frame_done(frame_done), .cand_count(cand_count));

  dog_layer_stream #(.PIX_W(8), .LAYERS(3), .DOG_W(6), .COLS(COLS), .ROWS(ROWS), .BORDER(1)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode), .thresh(thresh[4:0]),
    .out_valid(out_valid6), .out_data(out_data6), .out_cand(out_cand6), .out_col(out_col6),
    .out_row(out_row6), .frame_done(frame_done6), .cand_count(cand_count6));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    nvec++;
    if (a !== x) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  function automatic int enc(input int df, input int w, input bit m);
    int lim, s;
    lim = 1 << (w - 1);
    s = df > lim - 1 ? lim - 1 : df < -lim ? -lim : df;
    if (m && s < 0) s = -s > lim - 1 ? lim - 1 : -s;
    return s;
  endfunction

  task automatic reset_model();
    exp_t e;
    e = '0;
    p = 0; acc9 = 0; acc6 = 0; cc9 = 0; cc6 = 0; tl = 0; ml = 0;
    q.delete();
    q.push_back(e);
    q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    chk("out_valid", out_valid, e.v);
    chk("out_valid_w6", out_valid6, e.v);
    chk("frame_done", frame_done, e.fd);
    chk("frame_done_w6", frame_done6, e.fd);
    chk("cand_count", cand_count, e.cc9);
    chk("cand_count_w6", cand_count6, e.cc6);
    if (out_valid) n_ov++;
    if (frame_done) n_fd++;
    if (e.v) begin
      chk("out_data", out_data, e.d9);
      chk("out_cand", out_cand, e.c9);
      chk("out_col", out_col, e.col);
      chk("out_row", out_row, e.row);
      chk("out_data_w6", out_data6, e.d6);
      chk("out_cand_w6", out_cand6, e.c6);
      chk("out_col_w6", out_col6, e.col);
      chk("out_row_w6", out_row6, e.row);
    end
  endtask

  task automatic step(input logic v, input logic [23:0] d, input logic m, input logic [7:0] t);
    exp_t e;
    int c, r, df, ad;
    bit mk;
    in_valid = v; in_data = d; mode = m; thresh = t;
    e = '0;
    if (v) begin
      c = p % COLS;
      r = p / COLS;
      if (p == 0) begin ml = m; tl = t; end
      mk = c < 1 || c >= COLS - 1 || r < 1 || r >= ROWS - 1;
      for (int j = 0; j < 2; j++) begin
        df = int'(d[(j+1)*8 +: 8]) - int'(d[j*8 +: 8]);
        ad = df < 0 ? -df : df;
        e.d9[j*9 +: 9] = mk ? 9'd0 : 9'(enc(df, 9, ml));
        e.d6[j*6 +: 6] = mk ? 6'd0 : 6'(enc(df, 6, ml));
        e.c9[j] = !mk && ad > tl;
        e.c6[j] = !mk && ad > tl % 32;
      end
      if (|e.c9) acc9++;
      if (|e.c6) acc6++;
      e.v = 1; e.col = 3'(c); e.row = 2'(r); e.fd = p == NPIX - 1;
      if (e.fd) begin cc9 = acc9; cc6 = acc6; acc9 = 0; acc6 = 0; end
      p = (p + 1) % NPIX;
    end
    e.cc9 = 20'(cc9);
    e.cc6 = 20'(cc6);
    q.push_back(e);
    @(negedge clk);
    check(q[0]);
    q.pop_front();
  endtask

  task automatic patch(input logic [17:0] d9, input logic [1:0] c9, input logic [11:0] d6, input logic [1:0] c6);
    exp_t e;
    e = q[q.size()-1];
    e.d9 = d9; e.c9 = c9; e.d6 = d6; e.c6 = c6;
    q[q.size()-1] = e;
  endtask

  task automatic drain();
    repeat (3) step(0, '0, 0, 0);
  endtask

  task automatic frame(input int gap, input bit rmt, input logic m0, input logic [7:0] t0);
    for (int k = 0; k < NPIX; k++) begin
      while ($urandom_range(0, 99) < gap) step(0, '0, m0, t0);
      step(1, 24'($urandom), rmt ? 1'($urandom) : m0, rmt ? 8'($urandom_range(0, 60)) : t0);
    end
  endtask

  initial begin
    int n0, f0;
    logic [23:0] d;
    tv[0] = '{{8'd30, 8'd50, 8'd10}, 40, -20, 31, -20, 2'b11};
    tv[1] = '{{8'd100, 8'd100, 8'd100}, 0, 0, 0, 0, 2'b00};
    tv[2] = '{{8'd0, 8'd255, 8'd0}, 255, -255, 31, -32, 2'b11};
    tv[3] = '{{8'd51, 8'd35, 8'd20}, 15, 16, 15, 16, 2'b10};
    tv[4] = '{{8'd255, 8'd0, 8'd200}, -200, 255, -32, 31, 2'b11};
    tv[5] = '{{8'd55, 8'd40, 8'd50}, -10, 15, -10, 15, 2'b00};
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_cand", out_cand, 0);
    chk("reset out_col", out_col, 0);
    chk("reset out_row", out_row, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset cand_count", cand_count, 0);
    rst = 0;
    reset_model();
    for (int k = 0; k < NPIX; k++)
      if (k >= 9 && k < 15) begin
        step(1, tv[k-9].din, 0, 15);
        patch({9'(tv[k-9].e1), 9'(tv[k-9].e0)}, tv[k-9].ec, {6'(tv[k-9].f1), 6'(tv[k-9].f0)}, tv[k-9].ec);
      end else step(1, 24'($urandom), 0, 15);
    drain();
    for (int k = 0; k < NPIX; k++) begin
      d = k == 0 ? {8'd0, 8'd255, 8'd0} : (k == 10 || k == 18) ? {8'd30, 8'd50, 8'd10} : 24'($urandom);
      step(1, d, k < 16, 15);
      if (k == 0) patch('0, '0, '0, '0);
      if (k == 10 || k == 18) patch({9'd20, 9'd40}, 2'b11, {6'd20, 6'd31}, 2'b11);
    end
    drain();
    for (int k = 0; k < NPIX; k++) begin
      step(1, k == 10 ? {8'd30, 8'd50, 8'd10} : 24'($urandom), 0, 15);
      if (k == 10) patch({9'(-20), 9'd40}, 2'b11, {6'(-20), 6'd31}, 2'b11);
    end
    drain();
    n0 = n_ov;
    f0 = n_fd;
    frame(30, 1, 0, 0);
    drain();
    chk("valid_count", n_ov - n0, NPIX);
    chk("frame_done_count", n_fd - f0, 1);
    frame(20, 1, 1, 10);
    drain();
    repeat (3) frame(10, 1, 0, 0);
    drain();
    repeat (13) step(1, 24'($urandom), 0, 20);
    #2 rst = 1;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_cand", out_cand, 0);
    chk("rst out_col", out_col, 0);
    chk("rst out_row", out_row, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst cand_count", cand_count, 0);
    chk("rst cand_count_w6", cand_count6, 0);
    @(negedge clk);
    rst = 0;
    reset_model();
    frame(15, 1, 0, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dog_layer_stream.md
DOG_LAYER_STREAM -- requirements
Module: dog_layer_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8, unsigned blurred-pixel width per layer.
REQ-002 SHALL have parameter LAYERS, default 4, number of Gaussian layers per input beat (min 2).
REQ-003 SHALL have parameter DOG_W, default 9, signed DoG result width.
REQ-004 SHALL have parameters COLS and ROWS, defaults 640 and 480, frame geometry.
REQ-005 SHALL have parameter BORDER, default 3, border pixels masked on each image edge.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, beat qualifier.
REQ-009 SHALL have port in_data, input, LAYERS*PIX_W, layer i at bits [i*PIX_W +: PIX_W], layer 0 least blurred.
REQ-010 SHALL have port mode, input, 1: 0 = signed DoG, 1 = absolute DoG.
REQ-011 SHALL have port thresh, input, DOG_W-1, unsigned candidate threshold.
REQ-012 SHALL have port out_valid, output, 1, result qualifier.
REQ-013 SHALL have port out_data, output, (LAYERS-1)*DOG_W, DoG j at bits [j*DOG_W +: DOG_W].
REQ-014 SHALL have port out_cand, output, LAYERS-1, per-DoG candidate flag.
REQ-015 SHALL have ports out_col and out_row, outputs, $clog2(COLS) and $clog2(ROWS), pixel coordinates of the current result.
REQ-016 SHALL have port frame_done, output, 1, single-cycle pulse on the last pixel of a frame.
REQ-017 SHALL have port cand_count, output, 20, candidate total for the last completed frame.

Function
REQ-018 SHALL compute d_j = layer(j+1) - layer(j), j = 0..LAYERS-2, in PIX_W+1 signed arithmetic.
REQ-019 SHALL saturate d_j to the DOG_W signed range when PIX_W+1 > DOG_W; no wrap-around.
REQ-020 SHALL output |d_j| in mode 1; |most-negative| saturates to the most-positive value.
REQ-021 SHALL set out_cand[j] = 1 iff |d_j| > thresh and the pixel is not masked.
REQ-022 SHALL mask the pixel when col < BORDER, col >= COLS-BORDER, row < BORDER, or row >= ROWS-BORDER; masked pixels output out_data = 0 and out_cand = 0, with out_valid still asserted.
REQ-023 SHALL have a fixed latency of 2 cycles: a beat accepted at edge N gives out_valid = 1 after edge N+2.
REQ-024 SHALL advance col on each accepted beat; on col = COLS-1, col SHALL wrap to 0 and row SHALL increment; on row = ROWS-1 with col = COLS-1, row SHALL wrap to 0.
REQ-025 SHALL hold counters and pipeline registers through in_valid gaps; out_valid SHALL be 0 for each bubble.
REQ-026 SHALL latch mode and thresh when pixel (0,0) is accepted and apply the latched values for the whole frame; mid-frame changes take effect from the next frame.
REQ-027 SHALL assert frame_done together with out_valid for the result of pixel (COLS-1, ROWS-1).
REQ-028 SHALL accumulate the number of results with any out_cand bit set; at frame_done, cand_count SHALL load the frame total, including the final pixel, and hold it until the next frame_done.
REQ-029 SHALL saturate the internal candidate accumulator at 2^20-1.
REQ-030 SHALL be a two-state pipeline controller per stage (EMPTY/FULL), with no backpressure; the source owns beat pacing.

Reset
REQ-031 SHALL, on rst = 1, asynchronously clear out_valid, out_data, out_cand, out_col, out_row, frame_done, cand_count, the counters, the accumulator, and the latched mode/thresh (0).
REQ-032 SHALL, on rst mid-frame, discard in-flight beats; the first beat after release is pixel (0,0).

Verification (COLS=8, ROWS=4, BORDER=1, LAYERS=3, PIX_W=8, DOG_W=9)
REQ-033 SHALL check: pixel (2,1), layers {10,50,30}, mode 0, thresh 15 -> 2 cycles later out_data = {-20,+40}, out_cand = 2'b11.
REQ-034 SHALL check: the same beat with mode 1 latched at frame start -> out_data = {20,40}; toggling mode mid-frame has no effect until the next frame.
REQ-035 SHALL check: pixel (0,0), layers {0,255,0} -> out_data = 0, out_cand = 0, out_valid = 1.
REQ-036 SHALL check: DOG_W=6 build, layers {0,255,0} at an interior pixel -> d_0 = +31, d_1 = -32 (saturated).
REQ-037 SHALL check: 32 beats with random in_valid gaps -> exactly 32 out_valid, one frame_done on (7,3), and cand_count equal to the golden count, held through the next frame.
REQ-038 SHALL check: rst pulsed after 13 beats -> all outputs 0 within the same cycle; the next beat reports out_col = 0, out_row = 0.
